dual_port_ram: RTL and testbench
================================

Name: dual_port_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one independent read port, 4096 words x 64 bits by default.
- Both ports share a single clock.
- Used as a generic storage macro; write and read requests arrive from independent agents and may target any address in the same cycle.

Parameters:
- DATA_WIDTH, 64, width of each stored word and of in/out.
- ADDR_WIDTH, 12, width of wr_add/rd_add.
- DEPTH, 2**ADDR_WIDTH (4096), number of words; every address 0..DEPTH-1 is valid.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- wr  input  1  write enable.
- wr_add  input  ADDR_WIDTH  write address.
- in  input  DATA_WIDTH  write data.
- rd  input  1  read enable.
- rd_add  input  ADDR_WIDTH  read address.
- out  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a rising edge with rst=1, out <= 0.
  - Writes and reads are suppressed in that cycle.
  - Memory array contents are not cleared by reset; contents at power-up are undefined.
- Write:
  - On a rising edge with rst=0 and wr=1, mem[wr_add] <= in.
  - wr=0 leaves memory unchanged.
  - No handshake; every accepted write completes in that edge.
- Read:
  - On a rising edge with rst=0 and rd=1, out <= mem[rd_add].
  - Data is visible on out after that edge, i.e. 1-cycle latency from sampling rd/rd_add.
  - With rd=0, out holds its previous value; it is not cleared.
- Simultaneous write and read, different addresses: both proceed independently in the same edge.
- Simultaneous write and read, same address (read-first):
  - out receives the OLD content of the location.
  - The new data is returned by a read in any later cycle.
- Back-to-back:
  - Writes may issue every cycle.
  - Reads may issue every cycle; each edge with rd=1 updates out with that edge's rd_add.
- Addressing: full ADDR_WIDTH decode, no aliasing or wrap. Addresses 0 and DEPTH-1 are ordinary locations.
- Reset mid-operation:
  - A write presented in a reset cycle is lost.
  - Previously written locations retain their data across reset.
  - A read presented in a reset cycle yields out=0.
- X-handling: unknown wr or rd must not corrupt memory in simulation. Treat a non-1 enable as inactive.
- Synthesis: inferable as a block RAM. The memory array is a plain reg array with no reset, and out is the only register with a reset.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, rd=0/wr=0 -> out=0; after release with rd=0, out stays 0.
- Write/read basic:
  - Write 64'hDEAD_BEEF_0123_4567 to 12'h005; next cycle rd=1, rd_add=12'h005 -> out=64'hDEAD_BEEF_0123_4567 one cycle after rd sampled.
  - Then rd=0 -> out holds that value.
- Boundary addresses:
  - Write 64'h1 to 12'h000 and 64'hFFFF_FFFF_FFFF_FFFF to 12'hFFF.
  - Read both back -> exact values, no aliasing between them.
- Same-address collision:
  - Location 12'h010 holds 64'hAAAA.
  - In one cycle assert wr=1 (in=64'h5555) and rd=1, both at 12'h010 -> out=64'hAAAA.
  - Following read -> out=64'h5555.
- Streaming: write addresses 0..15 with data=addr*3 on consecutive cycles, then read 0..15 on consecutive cycles -> out sequence 0,3,...,45, one per cycle, 1-cycle latency.
- Reset mid-operation:
  - Write 64'h77 to 12'h020.
  - Assert rst for one cycle while wr=1 (12'h021, data 64'h99) and rd=1 (12'h020) -> out=0 that cycle.
  - Later read of 12'h020 -> 64'h77; 12'h021 was not written.

Source files
------------

// File: rtl/dual_port_ram.sv
// dual_port_ram
//   Simple dual-port synchronous RAM: one write port and one independent read
//   port on a single clock. Read-first on a same-address collision: the read
//   returns the contents held before the write on that edge.
//
// Ports
//   clk     clock; all state changes on the rising edge
//   rst     synchronous active-high reset; clears out and blocks that cycle's
//           write and read
//   wr      write enable
//   wr_add  write address
//   in      write data
//   rd      read enable
//   rd_add  read address
//   out     registered read data (1-cycle latency); holds its value while rd=0
//
// The array itself has no reset so that it maps onto a block RAM; out is the
// only register that is reset.
module dual_port_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_add,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] rd_add,
  output logic [DATA_WIDTH-1:0] out
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  wr_en;
  logic                  rd_en;

  // An unknown enable evaluates false in the conditions below, so it is
  // treated as inactive and cannot corrupt the array.
  assign wr_en = (wr === 1'b1) && (rst === 1'b0);
  assign rd_en = (rd === 1'b1);

  // Write port: no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_add] <= in;
    end
  end

  // Read data is taken from the array before this edge's write lands, which
  // gives read-first behaviour on a same-address collision.
  always_comb begin
    out_d = out_q;
    if (rd_en) begin
      out_d = mem_q[rd_add];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

  localparam int DW    = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [AW-1:0] wr_add;
  logic [DW-1:0] in;
  logic          rd;
  logic [AW-1:0] rd_add;
  logic [DW-1:0] out;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .wr_add (wr_add),
    .in     (in),
    .rd     (rd),
    .rd_add (rd_add),
    .out    (out)
  );

  always #5 clk = ~clk;

  // Reference model: contents of every location ever written, plus the value
  // out should show. Unwritten locations are undefined, so reads of them make
  // the expected output unknown until the next defined read or reset.
  logic [DW-1:0] model_mem [DEPTH];
  bit            model_known [DEPTH];
  logic [DW-1:0] exp_out;
  bit            exp_valid;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  // One clock cycle: drive inputs away from the edge, apply the model's rules
  // at the edge, then compare out shortly after it.
  task automatic cyc(input logic r, input logic w, input int wa,
                     input logic [DW-1:0] d, input logic rd_i, input int ra,
                     input string tag);
    @(negedge clk);
    rst    = r;
    wr     = w;
    wr_add = AW'(wa);
    in     = d;
    rd     = rd_i;
    rd_add = AW'(ra);
    @(posedge clk);
    if (r === 1'b1) begin
      exp_out   = '0;
      exp_valid = 1'b1;
    end else begin
      if (rd_i === 1'b1) begin
        exp_valid = model_known[ra];
        exp_out   = model_mem[ra];
      end
      if (w === 1'b1) begin
        model_mem[wa]   = d;
        model_known[wa] = 1'b1;
      end
    end
    #1;
    if (exp_valid) check(tag, out, exp_out);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 0, '0, 1'b0, 0, tag);
  endtask

  initial begin
    int wa;
    int ra;
    logic w;
    logic r;
    logic rs;
    logic [DW-1:0] d;

    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
    exp_out   = '0;
    exp_valid = 1'b0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wr_add = '0; rd_add = '0; in = '0;

    // Reset then idle
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, "reset_c1");
    cyc(1'b1, 1'b0, 0, '0, 1'b0, 0, "reset_c2");
    idle("idle_after_reset");
    idle("idle_after_reset2");

    // Basic write/read, then hold
    cyc(1'b0, 1'b1, 'h005, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, "write_005");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h005, "read_005");
    idle("hold_005");
    idle("hold_005_2");

    // Boundary addresses
    cyc(1'b0, 1'b1, 'h000, 64'h1, 1'b0, 0, "write_000");
    cyc(1'b0, 1'b1, 'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, "write_fff");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h000, "read_000");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'hFFF, "read_fff");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h000, "read_000_again");

    // Same-address collision is read-first
    cyc(1'b0, 1'b1, 'h010, 64'hAAAA, 1'b0, 0, "write_010");
    cyc(1'b0, 1'b1, 'h010, 64'h5555, 1'b1, 'h010, "collision_old");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h010, "collision_new");

    // Write and read at different addresses in the same edge
    cyc(1'b0, 1'b1, 'h011, 64'h1234, 1'b1, 'h005, "wr_rd_diff");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h011, "read_011");

    // Streaming writes then streaming reads
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b1, a, DW'(a * 3), 1'b0, 0, "stream_wr");
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b0, 0, '0, 1'b1, a, "stream_rd");
    idle("stream_hold");

    // Reset mid-operation
    cyc(1'b0, 1'b1, 'h020, 64'h77, 1'b0, 0, "write_020");
    cyc(1'b1, 1'b1, 'h021, 64'h99, 1'b1, 'h020, "reset_mid");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h020, "read_020_after_rst");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h021, "read_021_after_rst");
    #1;
    checks++;
    assert (out !== 64'h99)
      else begin
        errors++;
        $error("FAIL write_lost_021: observed=%h expected=not 0000000000000099", out);
      end

    // Unknown write enable must not disturb memory
    cyc(1'b0, 1'bx, 'h020, 64'hBAD, 1'b0, 0, "x_wr");
    cyc(1'b0, 1'b0, 0, '0, 1'b1, 'h020, "read_020_after_x");

    // Randomised traffic on a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      wa = int'($urandom_range(0, 31));
      ra = int'($urandom_range(0, 31));
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 19) == 0);
      d  = {$urandom, $urandom};
      cyc(rs, w, wa, d, r, ra, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
